// File: rtl/npu_mem_responder.sv
// rtl/npu_mem_responder.sv - NPU instruction/DRAM memory responder
//
// Serves an NPU's instruction fetches from a host-loaded instruction memory
// and models a single-port read-first DRAM with a one-cycle read latency.
// Optional counters are built only when NPU_MEM_RESPONDER_COUNTERS_EN is defined.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               pulse: IDLE->RUN, DONE->IDLE
//   load_en/addr/data   host write port into instruction memory
//   get_instr/_addr     NPU fetch request (served only in RUN)
//   instruction         fetched word, held between fetches
//   instr_valid         high the cycle after a served fetch
//   dram_addr           DRAM address (read every cycle, write on strobe)
//   dram_write_enable   DRAM write strobe
//   output_data_DRAM    DRAM write data from NPU
//   input_data_DRAM     DRAM read data to NPU
//   done                high in DONE (END_CHAIN fetched)
//   fetch_count         served fetches, saturating (0 when counters disabled)
//   dram_wr_count       accepted DRAM writes, saturating (0 when disabled)
`timescale 1ns/1ps

module npu_mem_responder #(
  parameter int INSTR_WIDTH      = 47,
  parameter int INSTR_MEM_AWIDTH = 9,
  parameter int DRAM_DWIDTH      = 512,
  parameter int DRAM_AWIDTH      = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        load_en,
  input  logic [INSTR_MEM_AWIDTH-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]      load_data,
  input  logic                        get_instr,
  input  logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
  output logic [INSTR_WIDTH-1:0]      instruction,
  output logic                        instr_valid,
  input  logic [DRAM_AWIDTH-1:0]      dram_addr,
  input  logic                        dram_write_enable,
  input  logic [DRAM_DWIDTH-1:0]      output_data_DRAM,
  output logic [DRAM_DWIDTH-1:0]      input_data_DRAM,
  output logic                        done,
  output logic [15:0]                 fetch_count,
  output logic [15:0]                 dram_wr_count
);

  localparam logic [3:0] END_CHAIN = 4'd12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  logic [INSTR_WIDTH-1:0] imem [0:(1<<INSTR_MEM_AWIDTH)-1];
  logic [DRAM_DWIDTH-1:0] dmem [0:(1<<DRAM_AWIDTH)-1];

  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   fetch_served;
  logic                   dram_wr_accept;

  assign fetch_word     = imem[get_instr_addr];
  assign fetch_served   = (state == RUN) && get_instr;
  assign dram_wr_accept = rst && dram_write_enable;

  // Memories are never cleared; writes are merely blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && load_en)
      imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (dram_wr_accept)
      dmem[dram_addr] <= output_data_DRAM;
  end

  // Reads sample the array before this edge's write lands, giving read-first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      instruction     <= '0;
      instr_valid     <= 1'b0;
      input_data_DRAM <= '0;
      done            <= 1'b0;
    end else begin
      input_data_DRAM <= dmem[dram_addr];
      instr_valid     <= fetch_served;
      if (fetch_served)
        instruction <= fetch_word;
      case (state)
        IDLE: begin
          if (start)
            state <= RUN;
        end
        RUN: begin
          // done rises together with the instr_valid that carries END_CHAIN.
          if (get_instr && (fetch_word[INSTR_WIDTH-1 -: 4] == END_CHAIN)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NPU_MEM_RESPONDER_COUNTERS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] dram_wr_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt   <= '0;
      dram_wr_cnt <= '0;
    end else begin
      if (fetch_served && (fetch_cnt != 16'hFFFF))
        fetch_cnt <= fetch_cnt + 16'd1;
      if (dram_write_enable && (dram_wr_cnt != 16'hFFFF))
        dram_wr_cnt <= dram_wr_cnt + 16'd1;
    end
  end

  assign fetch_count   = fetch_cnt;
  assign dram_wr_count = dram_wr_cnt;
`else
  assign fetch_count   = 16'h0000;
  assign dram_wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_npu_mem_responder.sv
// tb/tb_npu_mem_responder.sv - directed self-checking bench for npu_mem_responder
`timescale 1ns/1ps

module tb_npu_mem_responder;

  localparam int IW  = 47;
  localparam int IAW = 9;
  localparam int DW  = 512;
  localparam int DAW = 9;

`ifdef NPU_MEM_RESPONDER_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [IW-1:0] END_WORD = {4'd12, 43'h000_0000_0ABC};

  logic           clk;
  logic           rst;
  logic           start;
  logic           load_en;
  logic [IAW-1:0] load_addr;
  logic [IW-1:0]  load_data;
  logic           get_instr;
  logic [IAW-1:0] get_instr_addr;
  logic [IW-1:0]  instruction;
  logic           instr_valid;
  logic [DAW-1:0] dram_addr;
  logic           dram_write_enable;
  logic [DW-1:0]  output_data_DRAM;
  logic [DW-1:0]  input_data_DRAM;
  logic           done;
  logic [15:0]    fetch_count;
  logic [15:0]    dram_wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  npu_mem_responder #(
    .INSTR_WIDTH(IW), .INSTR_MEM_AWIDTH(IAW), .DRAM_DWIDTH(DW), .DRAM_AWIDTH(DAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .get_instr(get_instr), .get_instr_addr(get_instr_addr),
    .instruction(instruction), .instr_valid(instr_valid),
    .dram_addr(dram_addr), .dram_write_enable(dram_write_enable),
    .output_data_DRAM(output_data_DRAM), .input_data_DRAM(input_data_DRAM),
    .done(done), .fetch_count(fetch_count), .dram_wr_count(dram_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    get_instr = 1'b0; get_instr_addr = '0; dram_addr = '0;
    dram_write_enable = 1'b0; output_data_DRAM = '0;
    step(); step();

    check("rst_instruction", instruction, '0);
    check("rst_instr_valid", instr_valid, '0);
    check("rst_dram_data", input_data_DRAM, '0);
    check("rst_done", done, '0);
    check("rst_fetch_count", fetch_count, '0);
    check("rst_dram_wr_count", dram_wr_count, '0);

    rst = 1'b1;
    load_en = 1'b1; load_addr = 9'd5; load_data = 47'h1234; step();
    load_addr = 9'd6; load_data = 47'h2222; step();
    load_addr = 9'd7; load_data = END_WORD; step();
    load_en = 1'b0;

    // fetch while IDLE is ignored
    get_instr = 1'b1; get_instr_addr = 9'd5; step();
    get_instr = 1'b0;
    check("idle_instr_valid", instr_valid, '0);
    check("idle_instruction", instruction, '0);
    check("idle_fetch_count", fetch_count, '0);

    start = 1'b1; step(); start = 1'b0;
    get_instr = 1'b1; get_instr_addr = 9'd5; step();
    get_instr = 1'b0;
    check("fetch5_valid", instr_valid, 1'b1);
    check("fetch5_instruction", instruction, 47'h1234);
    check("fetch5_count", fetch_count, cnt(1));
    step();
    check("gap_valid", instr_valid, 1'b0);
    check("gap_instruction_hold", instruction, 47'h1234);

    // load and fetch the same address in one cycle: old data comes back
    load_en = 1'b1; load_addr = 9'd6; load_data = 47'h3333;
    get_instr = 1'b1; get_instr_addr = 9'd6; step();
    load_en = 1'b0; get_instr = 1'b0;
    check("rdfirst_imem", instruction, 47'h2222);
    step();
    get_instr = 1'b1; step(); get_instr = 1'b0;
    check("imem_new_data", instruction, 47'h3333);
    check("fetch6_count", fetch_count, cnt(3));

    // END_CHAIN
    get_instr = 1'b1; get_instr_addr = 9'd7; step();
    check("end_valid", instr_valid, 1'b1);
    check("end_done", done, 1'b1);
    check("end_instruction", instruction, END_WORD);
    get_instr_addr = 9'd5; step(); get_instr = 1'b0;
    check("done_fetch_ignored", instr_valid, 1'b0);
    check("done_instruction_hold", instruction, END_WORD);
    check("done_sticky", done, 1'b1);
    check("done_fetch_count", fetch_count, cnt(4));
    start = 1'b1; step(); start = 1'b0;
    check("done_to_idle", done, 1'b0);

    // start in RUN is ignored, so the fetch after it is still served
    start = 1'b1; step(); step(); start = 1'b0;
    get_instr = 1'b1; get_instr_addr = 9'd5; step(); get_instr = 1'b0;
    check("run_start_ignored", instr_valid, 1'b1);
    check("refetch_count", fetch_count, cnt(5));

    // DRAM
    dram_addr = 9'd3; dram_write_enable = 1'b1; output_data_DRAM = 512'hA5; step();
    dram_write_enable = 1'b0; step();
    check("dram_read_a5", input_data_DRAM, 512'hA5);
    dram_write_enable = 1'b1; output_data_DRAM = 512'h5A; step();
    dram_write_enable = 1'b0;
    check("dram_rdfirst", input_data_DRAM, 512'hA5);
    step();
    check("dram_read_5a", input_data_DRAM, 512'h5A);
    check("dram_wr_count2", dram_wr_count, cnt(2));

    // reset with a fetch, a load and a DRAM write pending
    get_instr = 1'b1; get_instr_addr = 9'd5;
    load_en = 1'b1; load_addr = 9'd5; load_data = 47'h7777;
    dram_write_enable = 1'b1; output_data_DRAM = 512'hFF;
    rst = 1'b0; step();
    get_instr = 1'b0; load_en = 1'b0; dram_write_enable = 1'b0;
    check("rst_mid_valid", instr_valid, 1'b0);
    check("rst_mid_instruction", instruction, '0);
    check("rst_mid_dram", input_data_DRAM, '0);
    check("rst_mid_fetch_count", fetch_count, '0);
    check("rst_mid_wr_count", dram_wr_count, '0);
    rst = 1'b1; step();
    check("rst_wr_discarded", input_data_DRAM, 512'h5A);
    start = 1'b1; step(); start = 1'b0;
    get_instr = 1'b1; get_instr_addr = 9'd5; step(); get_instr = 1'b0;
    check("imem_survives_rst", instruction, 47'h1234);

    // saturation of the DRAM write counter
    dram_addr = 9'd10; dram_write_enable = 1'b1;
    repeat (65534) step();
    check("wr_count_65534", dram_wr_count, cnt(65534));
    step();
    check("wr_count_65535", dram_wr_count, cnt(65535));
    repeat (70000 - 65535) step();
    dram_write_enable = 1'b0;
    check("wr_count_sat", dram_wr_count, CNT_EN ? 16'hFFFF : 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_mem_responder.md
NPU_MEM_RESPONDER -- requirements
Module: npu_mem_responder

Interface
REQ-001 Parameter INSTR_WIDTH, default 47: instruction word width; opcode occupies bits [INSTR_WIDTH-1 -: 4].
REQ-002 Parameter INSTR_MEM_AWIDTH, default 9: instruction memory address width (512 words).
REQ-003 Parameter DRAM_DWIDTH, default 512: DRAM data width.
REQ-004 Parameter DRAM_AWIDTH, default 9: DRAM address width (512 words).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins program service.
REQ-008 load_en  in  1  host write strobe to instruction memory.
REQ-009 load_addr  in  INSTR_MEM_AWIDTH  host write address.
REQ-010 load_data  in  INSTR_WIDTH  host write data.
REQ-011 get_instr  in  1  NPU fetch request.
REQ-012 get_instr_addr  in  INSTR_MEM_AWIDTH  NPU fetch address.
REQ-013 instruction  out  INSTR_WIDTH  fetched instruction to NPU.
REQ-014 instr_valid  out  1  instruction updated this cycle.
REQ-015 dram_addr  in  DRAM_AWIDTH  NPU DRAM address.
REQ-016 dram_write_enable  in  1  NPU DRAM write strobe.
REQ-017 output_data_DRAM  in  DRAM_DWIDTH  NPU write data.
REQ-018 input_data_DRAM  out  DRAM_DWIDTH  read data to NPU.
REQ-019 done  out  1  sticky; END_CHAIN fetched.
REQ-020 fetch_count  out  16  fetches served, saturating.
REQ-021 dram_wr_count  out  16  DRAM writes accepted, saturating.

Function
REQ-022 States IDLE, RUN, DONE; reset enters IDLE.
REQ-023 IDLE->RUN on start; RUN->DONE when a served instruction has opcode 12 (END_CHAIN); DONE->IDLE on start; start in RUN ignored.
REQ-024 Host load writes imem[load_addr]<=load_data in any state, every cycle load_en=1.
REQ-025 Fetch served only in RUN: get_instr=1 at cycle N -> instruction=imem[get_instr_addr] and instr_valid=1 at N+1.
REQ-026 get_instr in IDLE/DONE ignored: instr_valid=0, instruction holds, fetch_count unchanged.
REQ-027 instr_valid is 0 in any cycle not following a served fetch; instruction holds last value otherwise.
REQ-028 Load and fetch to same address same cycle: fetch returns pre-write data (read-first).
REQ-029 DRAM write: dram_write_enable=1 at N -> dmem[dram_addr]<=output_data_DRAM, any state.
REQ-030 DRAM read every cycle: input_data_DRAM at N+1 = dmem[dram_addr at N], pre-write data when writing same address (read-first).
REQ-031 done=1 in DONE only; asserts same cycle as instr_valid carrying END_CHAIN.
REQ-032 Counters increment by 1 per served fetch / DRAM write, saturate at 16'hFFFF, no wrap.
REQ-033 Memories not reset; contents preserved across reset.

Reset
REQ-034 rst=0 at a clock edge: state=IDLE, instruction=0, instr_valid=0, input_data_DRAM=0, done=0, fetch_count=0, dram_wr_count=0.
REQ-035 Reset mid-fetch cancels response: no instr_valid in cycle after reset.
REQ-036 Loads and DRAM writes presented while rst=0 are discarded.

Configuration
REQ-037 Macro NPU_MEM_RESPONDER_COUNTERS_EN: defined -> fetch_count/dram_wr_count per REQ-032; undefined -> both outputs constant 0, no counter registers.

Verification
REQ-038 Load imem[5]=47'h1234, start, get_instr addr 5 -> next cycle instruction=47'h1234, instr_valid=1, fetch_count=1.
REQ-039 In IDLE, get_instr addr 5 -> instr_valid=0, instruction=0, fetch_count=0.
REQ-040 Load imem[7] opcode 12, RUN, fetch 7 -> done=1 with instr_valid; further fetches ignored; start -> IDLE, done=0.
REQ-041 DRAM write addr 3 data 512'hA5 then read addr 3 -> input_data_DRAM=512'hA5; write+read same cycle addr 3 new 512'h5A -> returns 512'hA5.
REQ-042 70000 DRAM writes -> dram_wr_count=16'hFFFF (macro defined), 0 (undefined).
REQ-043 rst=0 in cycle after get_instr -> instr_valid=0, all outputs 0; imem[5] still 47'h1234 after restart.
